pattern_search_engine: RTL

- Parametrised multi-byte pattern search over a single-port block RAM (blk_mem_gen style, read-only use).
- Latches a pattern of 1..MAX_PAT symbols, a base address and a block length, then walks the block and reports the first matching address.
- Supports resume: continues from the symbol after the last match, so the host can enumerate all occurrences.
- Sits between the host control logic and the BRAM; it is the sole driver of the BRAM address and enable.

---
 rtl/search_pkg.sv | 29 ++
 rtl/search_cmp_unit.sv | 34 +++
 rtl/pattern_search_engine.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/search_pkg.sv
// ---------------------------------------------------------------------------
// search_pkg: shared FSM state type, width helper and default BRAM geometry.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package search_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/search_cmp_unit.sv
// ---------------------------------------------------------------------------
// search_cmp_unit: selects pattern symbol i_sel and compares it with i_data.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module search_cmp_unit
  import search_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_PAT = 8
) (
  input  logic [MAX_PAT*DATA_W-1:0]      i_pattern,
  input  logic [clog2(MAX_PAT+1)-1:0]    i_sel,
  input  logic [DATA_W-1:0]              i_data,
  output logic                           o_eq
);

  localparam int SEL_W = clog2(MAX_PAT + 1);

  logic [DATA_W-1:0] w_sym;

  always_comb begin
    w_sym = '0;
    for (int n = 0; n < MAX_PAT; n++) begin
      if (i_sel == SEL_W'(n)) w_sym = i_pattern[n*DATA_W +: DATA_W];
    end
  end

  assign o_eq = (w_sym == i_data);

endmodule

`default_nettype wire

// File: rtl/pattern_search_engine.sv
// ---------------------------------------------------------------------------
// pattern_search_engine: walks a BRAM block and reports the first address
// where a 1..MAX_PAT symbol pattern matches; resumable. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pattern_search_engine
  import search_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_PAT = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          resume,
  input  logic [MAX_PAT*DATA_W-1:0]     pattern,
  input  logic [clog2(MAX_PAT+1)-1:0]   pat_len,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W:0]               blk_len,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_dout,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [ADDR_W-1:0]             match_addr
);

  localparam int PLW       = clog2(MAX_PAT + 1);
  localparam int OW        = ADDR_W + 1;
  localparam int WCW       = (MEM_LAT > 2) ? clog2(MEM_LAT) : 1;
  localparam int WAIT_LAST = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

  state_t                    r_state, w_state_nxt;
  logic [MAX_PAT*DATA_W-1:0] r_pat;
  logic [PLW-1:0]            r_pat_len, r_j, w_j_nxt;
  logic [ADDR_W-1:0]         r_base, r_match_addr, w_match_nxt;
  logic [ADDR_W-1:0]         r_mem_addr, w_addr_nxt, w_base_src;
  logic [OW-1:0]             r_last, r_k, w_k_nxt, w_k_inc;
  logic [WCW-1:0]            r_wcnt, w_wcnt_nxt;
  logic                      r_found, w_found_nxt, r_mem_en;
  logic                      w_load, w_degen, w_eq, w_busy_nxt;

  search_cmp_unit #(
    .DATA_W  (DATA_W),
    .MAX_PAT (MAX_PAT)
  ) u_cmp (
    .i_pattern (r_pat),
    .i_sel     (r_j),
    .i_data    (mem_dout),
    .o_eq      (w_eq)
  );

  assign w_degen = (pat_len == '0) || (pat_len > PLW'(MAX_PAT)) ||
                   (blk_len < OW'(pat_len));
  assign w_k_inc = r_k + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_found_nxt = r_found;
    w_match_nxt = r_match_addr;
    w_wcnt_nxt  = '0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) begin
          w_load      = 1'b1;
          w_k_nxt     = '0;
          w_j_nxt     = '0;
          w_found_nxt = 1'b0;
          w_state_nxt = w_degen ? S_FIN : S_ISSUE;
        end else if (resume && (r_state == S_FIN) && r_found) begin
          w_k_nxt     = w_k_inc;
          w_j_nxt     = '0;
          w_found_nxt = 1'b0;
          w_state_nxt = (w_k_inc > r_last) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = (MEM_LAT > 1) ? S_WAIT : S_CMP;
      S_WAIT: begin
        w_wcnt_nxt = r_wcnt + 1'b1;
        if (r_wcnt == WCW'(WAIT_LAST)) begin
          w_wcnt_nxt  = '0;
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (w_eq && (r_j == r_pat_len - 1'b1)) begin
          w_found_nxt = 1'b1;
          w_match_nxt = r_base + r_k[ADDR_W-1:0];
          w_state_nxt = S_FIN;
        end else if (w_eq) begin
          w_j_nxt     = r_j + 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_j_nxt     = '0;
          w_k_nxt     = w_k_inc;
          w_state_nxt = (w_k_inc > r_last) ? S_FIN : S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Enable stays up through WAIT/CMP so a pipelined BRAM keeps advancing.
  assign w_busy_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT) ||
                      (w_state_nxt == S_CMP);
  assign w_base_src = w_load ? base_addr : r_base;
  assign w_addr_nxt = w_base_src + w_k_nxt[ADDR_W-1:0] + ADDR_W'(w_j_nxt);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pat        <= '0;
      r_pat_len    <= '0;
      r_base       <= '0;
      r_last       <= '0;
      r_k          <= '0;
      r_j          <= '0;
      r_wcnt       <= '0;
      r_found      <= 1'b0;
      r_match_addr <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_j          <= w_j_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_found      <= w_found_nxt;
      r_match_addr <= w_match_nxt;
      r_mem_en     <= w_busy_nxt;
      if (w_busy_nxt) r_mem_addr <= w_addr_nxt;
      if (w_load) begin
        r_pat     <= pattern;
        r_pat_len <= pat_len;
        r_base    <= base_addr;
        r_last    <= blk_len - OW'(pat_len);
      end
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_addr   = r_mem_addr;
  assign busy       = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_CMP);
  assign done       = (r_state == S_FIN);
  assign found      = r_found;
  assign match_addr = r_match_addr;

endmodule

`default_nettype wire
